// File: rtl/serv_bus_arbiter.sv
// Merges SERV's instruction bus and data bus onto one Wishbone-style core bus.
// One transaction in flight, registered outputs, watchdog abort when the slave never acks.
module serv_bus_arbiter #(
  parameter string       PRIORITY       = "DBUS",
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  output logic        o_core_cyc,
  output logic        o_core_stb,
  output logic        o_core_we,
  output logic [3:0]  o_core_wstrb,
  output logic [31:0] o_core_addr,
  output logic [31:0] o_core_data_out,
  input  logic [31:0] i_core_data_in,
  input  logic        i_core_ack,
  output logic        o_timeout
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} state_e;

  localparam bit          RR_MODE  = (PRIORITY == "RR");
  localparam bit          WDT_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] WDT_LAST = WDT_EN ? TIMEOUT_CYCLES - 1 : 32'd0;

  state_e      r_state;
  state_e      w_next_state;
  logic        r_prefer_i;
  logic [31:0] r_wdt;

  logic        w_granted;
  logic        w_pick_d;
  logic        w_pick_i;
  logic        w_grant_d;
  logic        w_grant_i;
  logic        w_expire;
  logic        w_done;
  logic        w_ack_i;
  logic        w_ack_d;
  logic [31:0] w_rdt;

  always_ff @(posedge clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_pick_d)      w_next_state = GRANT_D;
        else if (w_pick_i) w_next_state = GRANT_I;
      end
      GRANT_I, GRANT_D: begin
        if (w_done) w_next_state = RELEASE;
      end
      RELEASE: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // In RR mode a simultaneous request goes to whichever master was not granted last.
  always_comb begin
    w_granted = (r_state == GRANT_I) || (r_state == GRANT_D);
    w_pick_d  = i_dbus_cyc && (!i_ibus_cyc || !RR_MODE || !r_prefer_i);
    w_pick_i  = i_ibus_cyc && !w_pick_d;
    w_grant_d = (r_state == IDLE) && w_pick_d;
    w_grant_i = (r_state == IDLE) && w_pick_i;
    w_expire  = WDT_EN && w_granted && !i_core_ack && (r_wdt == WDT_LAST);
    w_done    = w_granted && (i_core_ack || w_expire);
    w_ack_i   = (r_state == GRANT_I) && w_done;
    w_ack_d   = (r_state == GRANT_D) && w_done;
    w_rdt     = i_core_ack ? i_core_data_in : 32'h0;
  end

  assign o_core_stb = o_core_cyc;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      o_core_cyc      <= 1'b0;
      o_core_we       <= 1'b0;
      o_core_wstrb    <= 4'b0000;
      o_core_addr     <= 32'h0;
      o_core_data_out <= 32'h0;
      o_ibus_ack      <= 1'b0;
      o_dbus_ack      <= 1'b0;
      o_ibus_rdt      <= 32'h0;
      o_dbus_rdt      <= 32'h0;
      o_timeout       <= 1'b0;
      r_prefer_i      <= 1'b1;
      r_wdt           <= 32'h0;
    end else begin
      o_ibus_ack <= w_ack_i;
      o_dbus_ack <= w_ack_d;
      if (w_ack_i)  o_ibus_rdt <= w_rdt;
      if (w_ack_d)  o_dbus_rdt <= w_rdt;
      if (w_expire) o_timeout  <= 1'b1;

      // Request fields are captured only at the grant edge and held for the whole transaction.
      if (w_grant_i) begin
        o_core_cyc      <= 1'b1;
        o_core_we       <= 1'b0;
        o_core_wstrb    <= 4'b0000;
        o_core_addr     <= i_ibus_adr;
        o_core_data_out <= 32'h0;
        r_prefer_i      <= 1'b0;
      end else if (w_grant_d) begin
        o_core_cyc      <= 1'b1;
        o_core_we       <= i_dbus_we;
        o_core_wstrb    <= i_dbus_we ? i_dbus_sel : 4'b0000;
        o_core_addr     <= i_dbus_adr;
        o_core_data_out <= i_dbus_dat;
        r_prefer_i      <= 1'b1;
      end else if (w_done) begin
        o_core_cyc      <= 1'b0;
      end

      if (w_grant_i || w_grant_d)
        r_wdt <= 32'h0;
      else if (WDT_EN && w_granted && !i_core_ack)
        r_wdt <= r_wdt + 32'd1;
    end
  end

endmodule

// File: tb/tb_serv_bus_arbiter.sv
// Randomized bench for serv_bus_arbiter: a DBUS-priority and an RR instance run side by side
// against a transaction timeline model that predicts grants, acks, read data and watchdog aborts.
module tb_serv_bus_arbiter;

  localparam int T    = 16;
  localparam int NDUT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ibusAdr   [NDUT];
  logic        ibusCyc   [NDUT];
  logic [31:0] ibusRdt   [NDUT];
  logic        ibusAck   [NDUT];
  logic [31:0] dbusAdr   [NDUT];
  logic [31:0] dbusDat   [NDUT];
  logic [3:0]  dbusSel   [NDUT];
  logic        dbusWe    [NDUT];
  logic        dbusCyc   [NDUT];
  logic [31:0] dbusRdt   [NDUT];
  logic        dbusAck   [NDUT];
  logic        coreCyc   [NDUT];
  logic        coreStb   [NDUT];
  logic        coreWe    [NDUT];
  logic [3:0]  coreWstrb [NDUT];
  logic [31:0] coreAddr  [NDUT];
  logic [31:0] coreDout  [NDUT];
  logic [31:0] coreDin   [NDUT];
  logic        coreAck   [NDUT];
  logic        timeoutFlag [NDUT];

  int checks   = 0;
  int failures = 0;
  int roundNo  = 0;

  // Model state: RR preference, last read data per master, sticky watchdog flag.
  bit          nextI      [NDUT];
  logic [31:0] expRdtI    [NDUT];
  logic [31:0] expRdtD    [NDUT];
  bit          expTimeout [NDUT];

  always #5 clk = ~clk;

  serv_bus_arbiter #(.PRIORITY("DBUS"), .TIMEOUT_CYCLES(T)) dutDbus (
    .clk(clk), .i_rst(rst),
    .i_ibus_adr(ibusAdr[0]), .i_ibus_cyc(ibusCyc[0]), .o_ibus_rdt(ibusRdt[0]), .o_ibus_ack(ibusAck[0]),
    .i_dbus_adr(dbusAdr[0]), .i_dbus_dat(dbusDat[0]), .i_dbus_sel(dbusSel[0]), .i_dbus_we(dbusWe[0]),
    .i_dbus_cyc(dbusCyc[0]), .o_dbus_rdt(dbusRdt[0]), .o_dbus_ack(dbusAck[0]),
    .o_core_cyc(coreCyc[0]), .o_core_stb(coreStb[0]), .o_core_we(coreWe[0]), .o_core_wstrb(coreWstrb[0]),
    .o_core_addr(coreAddr[0]), .o_core_data_out(coreDout[0]), .i_core_data_in(coreDin[0]),
    .i_core_ack(coreAck[0]), .o_timeout(timeoutFlag[0])
  );

  serv_bus_arbiter #(.PRIORITY("RR"), .TIMEOUT_CYCLES(T)) dutRr (
    .clk(clk), .i_rst(rst),
    .i_ibus_adr(ibusAdr[1]), .i_ibus_cyc(ibusCyc[1]), .o_ibus_rdt(ibusRdt[1]), .o_ibus_ack(ibusAck[1]),
    .i_dbus_adr(dbusAdr[1]), .i_dbus_dat(dbusDat[1]), .i_dbus_sel(dbusSel[1]), .i_dbus_we(dbusWe[1]),
    .i_dbus_cyc(dbusCyc[1]), .o_dbus_rdt(dbusRdt[1]), .o_dbus_ack(dbusAck[1]),
    .o_core_cyc(coreCyc[1]), .o_core_stb(coreStb[1]), .o_core_we(coreWe[1]), .o_core_wstrb(coreWstrb[1]),
    .o_core_addr(coreAddr[1]), .o_core_data_out(coreDout[1]), .i_core_data_in(coreDin[1]),
    .i_core_ack(coreAck[1]), .o_timeout(timeoutFlag[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic resetModel();
    for (int d = 0; d < NDUT; d++) begin
      nextI[d]      = 1'b1;
      expRdtI[d]    = 32'h0;
      expRdtD[d]    = 32'h0;
      expTimeout[d] = 1'b0;
    end
  endtask

  // One round: the chosen masters raise cyc together; lat is the grant cycle on which the
  // slave acks (values above T mean it never does). Timeline is derived from the bus rules:
  // cyc for min(lat,T) cycles, master ack one cycle later, then two idle cycles before a
  // waiting master's grant becomes visible.
  task automatic applyStimulus(input bit reqI, input bit reqD, input int lat0, input int lat1,
                               input bit scramble, input bit dropEarly,
                               input logic [31:0] iAdr, input logic [31:0] dAdr,
                               input logic [31:0] dDat, input logic [3:0] dSel, input logic dWe,
                               input logic [31:0] sDat0, input logic [31:0] sDat1);
    int n, h0, h1, ack0, ack1, endN;
    bit firstD [NDUT];
    roundNo++;
    n    = int'(reqI) + int'(reqD);
    h0   = (lat0 < T) ? lat0 : T;
    h1   = (lat1 < T) ? lat1 : T;
    ack0 = (n >= 1) ? h0 + 1 : -100;
    ack1 = (n == 2) ? h0 + h1 + 3 : -100;
    endN = (n == 2) ? ack1 + 1 : (n == 1) ? ack0 + 1 : 3;
    for (int d = 0; d < NDUT; d++) begin
      firstD[d] = reqD && (!reqI || d == 0 || !nextI[d]);
      if (n == 2)      nextI[d] = !firstD[d];
      else if (n == 1) nextI[d] = reqD;
      ibusAdr[d] = iAdr;  ibusCyc[d] = reqI;
      dbusAdr[d] = dAdr;  dbusDat[d] = dDat; dbusSel[d] = dSel;
      dbusWe[d]  = dWe;   dbusCyc[d] = reqD;
    end
    for (int c = 1; c <= endN; c++) begin
      bit inG0, inG1, expCyc;
      @(negedge clk);
      inG0   = (n >= 1) && (c <= h0);
      inG1   = (n == 2) && (c >= h0 + 3) && (c <= h0 + 2 + h1);
      expCyc = inG0 || inG1;
      for (int d = 0; d < NDUT; d++) begin
        bit txnD, expAckI, expAckD;
        string pfx;
        pfx     = $sformatf("rnd%0d/dut%0d/c%0d", roundNo, d, c);
        txnD    = inG0 ? firstD[d] : !firstD[d];
        expAckI = 1'b0;
        expAckD = 1'b0;
        if (c == ack0) begin
          if (firstD[d]) begin expAckD = 1'b1; expRdtD[d] = (lat0 <= T) ? sDat0 : 32'h0; end
          else begin expAckI = 1'b1; expRdtI[d] = (lat0 <= T) ? sDat0 : 32'h0; end
          if (lat0 > T) expTimeout[d] = 1'b1;
        end
        if (c == ack1) begin
          if (!firstD[d]) begin expAckD = 1'b1; expRdtD[d] = (lat1 <= T) ? sDat1 : 32'h0; end
          else begin expAckI = 1'b1; expRdtI[d] = (lat1 <= T) ? sDat1 : 32'h0; end
          if (lat1 > T) expTimeout[d] = 1'b1;
        end
        checkOutput({pfx, ".cyc"}, 32'(coreCyc[d]), 32'(expCyc));
        checkOutput({pfx, ".stb"}, 32'(coreStb[d]), 32'(expCyc));
        checkOutput({pfx, ".ibusAck"}, 32'(ibusAck[d]), 32'(expAckI));
        checkOutput({pfx, ".dbusAck"}, 32'(dbusAck[d]), 32'(expAckD));
        checkOutput({pfx, ".ibusRdt"}, ibusRdt[d], expRdtI[d]);
        checkOutput({pfx, ".dbusRdt"}, dbusRdt[d], expRdtD[d]);
        checkOutput({pfx, ".timeout"}, 32'(timeoutFlag[d]), 32'(expTimeout[d]));
        if (expCyc) begin
          checkOutput({pfx, ".addr"}, coreAddr[d], txnD ? dAdr : iAdr);
          checkOutput({pfx, ".we"}, 32'(coreWe[d]), txnD ? 32'(dWe) : 32'h0);
          checkOutput({pfx, ".wstrb"}, 32'(coreWstrb[d]), (txnD && dWe) ? 32'(dSel) : 32'h0);
          checkOutput({pfx, ".dataOut"}, coreDout[d], txnD ? dDat : 32'h0);
        end
        coreAck[d] = 1'b0;
        if (inG0 && c == lat0) begin
          coreAck[d] = 1'b1; coreDin[d] = sDat0;
        end else if (inG1 && c == h0 + 2 + lat1) begin
          coreAck[d] = 1'b1; coreDin[d] = sDat1;
        end else if (!expCyc && $urandom_range(0, 3) == 0) begin
          coreAck[d] = 1'b1; coreDin[d] = $urandom;
        end
        if (c == ack0 || (dropEarly && inG0 && c == 1)) begin
          if (firstD[d]) dbusCyc[d] = 1'b0; else ibusCyc[d] = 1'b0;
        end
        if (c == ack1) begin
          if (!firstD[d]) dbusCyc[d] = 1'b0; else ibusCyc[d] = 1'b0;
        end
        if (scramble && expCyc) begin
          if (txnD) begin
            dbusAdr[d] = $urandom; dbusDat[d] = $urandom; dbusSel[d] = 4'($urandom); dbusWe[d] = 1'($urandom);
          end else begin
            ibusAdr[d] = $urandom;
          end
        end
      end
    end
  endtask

  function automatic int pickLatency();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return T;
    if (r == 1) return T - 1;
    if (r == 2) return T + 1 + int'($urandom_range(0, 20));
    return int'($urandom_range(1, 6));
  endfunction

  initial begin
    rst = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      ibusAdr[d] = 32'h0; ibusCyc[d] = 1'b0; dbusAdr[d] = 32'h0; dbusDat[d] = 32'h0;
      dbusSel[d] = 4'h0;  dbusWe[d]  = 1'b0; dbusCyc[d] = 1'b0; coreDin[d] = 32'h0; coreAck[d] = 1'b0;
    end
    resetModel();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      checkOutput($sformatf("reset/dut%0d.cyc", d), 32'(coreCyc[d]), 32'h0);
      checkOutput($sformatf("reset/dut%0d.stb", d), 32'(coreStb[d]), 32'h0);
      checkOutput($sformatf("reset/dut%0d.we", d), 32'(coreWe[d]), 32'h0);
      checkOutput($sformatf("reset/dut%0d.wstrb", d), 32'(coreWstrb[d]), 32'h0);
      checkOutput($sformatf("reset/dut%0d.addr", d), coreAddr[d], 32'h0);
      checkOutput($sformatf("reset/dut%0d.dataOut", d), coreDout[d], 32'h0);
      checkOutput($sformatf("reset/dut%0d.acks", d), {30'h0, ibusAck[d], dbusAck[d]}, 32'h0);
      checkOutput($sformatf("reset/dut%0d.rdt", d), ibusRdt[d] | dbusRdt[d], 32'h0);
      checkOutput($sformatf("reset/dut%0d.timeout", d), 32'(timeoutFlag[d]), 32'h0);
    end

    $display("[TB] directed rounds");
    applyStimulus(1, 0, 1, 0, 0, 0, 32'h100, 32'h0, 32'h0, 4'h0, 1'b0, 32'h00000013, 32'h0);
    applyStimulus(0, 1, 2, 0, 0, 0, 32'h0, 32'h2004, 32'hDEADBEEF, 4'b0011, 1'b1, 32'h11111111, 32'h0);
    applyStimulus(1, 1, 1, 3, 0, 0, 32'h200, 32'h3000, 32'hCAFEF00D, 4'b1111, 1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A);
    applyStimulus(1, 1, 2, 1, 1, 0, 32'h204, 32'h3004, 32'h01234567, 4'b0100, 1'b1, 32'h0BADF00D, 32'h600DCAFE);
    applyStimulus(1, 0, T, 0, 0, 0, 32'h208, 32'h0, 32'h0, 4'h0, 1'b0, 32'h76543210, 32'h0);
    applyStimulus(1, 1, 1000, 2, 0, 0, 32'h20C, 32'h4000, 32'h89ABCDEF, 4'b1000, 1'b1, 32'hFFFFFFFF, 32'h12345678);
    applyStimulus(0, 1, 3, 0, 0, 1, 32'h0, 32'h4004, 32'h55AA55AA, 4'b0110, 1'b1, 32'h33333333, 32'h0);

    $display("[TB] random rounds");
    for (int r = 0; r < 40; r++) begin
      applyStimulus(1'($urandom), 1'($urandom), pickLatency(), pickLatency(),
                    1'($urandom), ($urandom_range(0, 3) == 0),
                    $urandom, $urandom, $urandom, 4'($urandom), 1'($urandom), $urandom, $urandom);
    end

    $display("[TB] reset during GRANT_D");
    for (int d = 0; d < NDUT; d++) begin
      ibusCyc[d] = 1'b0; dbusCyc[d] = 1'b1; dbusWe[d] = 1'b1;
      dbusAdr[d] = 32'h5000; dbusDat[d] = 32'hFEEDFACE; dbusSel[d] = 4'hF; coreAck[d] = 1'b0;
    end
    @(negedge clk);
    for (int d = 0; d < NDUT; d++)
      checkOutput($sformatf("midrst/dut%0d.granted", d), 32'(coreCyc[d]), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    resetModel();
    for (int d = 0; d < NDUT; d++) begin
      checkOutput($sformatf("midrst/dut%0d.cyc", d), 32'(coreCyc[d]), 32'h0);
      checkOutput($sformatf("midrst/dut%0d.dbusAck", d), 32'(dbusAck[d]), 32'h0);
      checkOutput($sformatf("midrst/dut%0d.timeout", d), 32'(timeoutFlag[d]), 32'h0);
      checkOutput($sformatf("midrst/dut%0d.dbusRdt", d), dbusRdt[d], 32'h0);
      dbusCyc[d] = 1'b0; coreAck[d] = 1'b1; coreDin[d] = 32'hBAADBAAD;
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        checkOutput($sformatf("midrst/dut%0d/k%0d.cyc", d, k), 32'(coreCyc[d]), 32'h0);
        checkOutput($sformatf("midrst/dut%0d/k%0d.acks", d, k), {30'h0, ibusAck[d], dbusAck[d]}, 32'h0);
        checkOutput($sformatf("midrst/dut%0d/k%0d.dbusRdt", d, k), dbusRdt[d], 32'h0);
        if (k == 1) coreAck[d] = 1'b0;
      end
    end
    applyStimulus(1, 1, 2, 2, 0, 0, 32'h300, 32'h6000, 32'h13579BDF, 4'b0001, 1'b1, 32'h2468ACE0, 32'h1357ACE0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
